// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
//   Runs one dual-port 128x16 SRAM macro as a single-clock FIFO. Port 1 of
//   the macro only writes and port 2 only reads. A 2-entry output buffer
//   hides the macro's registered 1-cycle read latency, so the consumer side
//   can sustain one word per cycle.
//
// Ports
//   clk, rst_n            clock (also feeds macro CE1/CE2), async active-low reset
//   flush                 synchronous clear (only with SRAM_FIFO_FLUSH_EN)
//   enq_valid/ready/data  producer handshake and write word
//   deq_valid/ready/data  consumer handshake and head word
//   count                 words held: SRAM + in-flight read + output buffer
//   sram_a1/i1/csb1/web1/oeb1  macro port 1 (write only), controls active low
//   sram_a2/csb2/web2/oeb2     macro port 2 (read only), controls active low
//   sram_o2               macro port 2 read data, valid after the issuing edge
//
// Build option
//   SRAM_FIFO_FLUSH_EN    adds the flush input
module sram_fifo_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SRAM_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_data,
    output logic [ADDR_W+1:0] count,
    output logic [ADDR_W-1:0] sram_a1,
    output logic [WIDTH-1:0]  sram_i1,
    output logic              sram_csb1,
    output logic              sram_web1,
    output logic              sram_oeb1,
    output logic [ADDR_W-1:0] sram_a2,
    output logic              sram_csb2,
    output logic              sram_web2,
    output logic              sram_oeb2,
    input  logic [WIDTH-1:0]  sram_o2
);

    localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W+1)'(DEPTH);

    logic              flush_i;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              inflight;
    logic [WIDTH-1:0]  ob0;
    logic [WIDTH-1:0]  ob1;
    logic [1:0]        ob_cnt;

    logic              enq_fire;
    logic              deq_fire;
    logic              rd_issue;
    logic [2:0]        occ_after_pop;

    logic [WIDTH-1:0]  ob0_n;
    logic [WIDTH-1:0]  ob1_n;
    logic [1:0]        ob_cnt_n;

`ifdef SRAM_FIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Handshakes. mem_cnt is registered, so a word written this cycle is
    // never visible to the read side until the next cycle.
    assign enq_ready = (mem_cnt != MEM_FULL) && !flush_i;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_valid = (ob_cnt != 2'd0) && !flush_i;
    assign deq_fire  = deq_valid && deq_ready;
    assign deq_data  = ob0;

    // Issue a read only if the buffer still has room once the in-flight
    // word lands and this cycle's pop is taken into account.
    assign occ_after_pop = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, deq_fire};
    assign rd_issue      = (mem_cnt != '0) && (occ_after_pop < 3'd2) && !flush_i;

    assign count = (ADDR_W+2)'(mem_cnt) + (ADDR_W+2)'(inflight) + (ADDR_W+2)'(ob_cnt);

    // SRAM port drive; controls are held inactive while in reset.
    assign sram_a1   = wr_ptr;
    assign sram_i1   = enq_data;
    assign sram_csb1 = !(enq_fire && rst_n);
    assign sram_web1 = !(enq_fire && rst_n);
    assign sram_oeb1 = 1'b1;
    assign sram_a2   = rd_ptr;
    assign sram_csb2 = !(rd_issue && rst_n);
    assign sram_oeb2 = !(rd_issue && rst_n);
    assign sram_web2 = 1'b1;

    // Output buffer: pop first, then append the landing read word at the
    // resulting tail, so pop+append with one entry refills ob0 directly.
    always_comb begin
        ob0_n    = ob0;
        ob1_n    = ob1;
        ob_cnt_n = ob_cnt;
        if (deq_fire) begin
            ob0_n    = ob1;
            ob_cnt_n = ob_cnt - 2'd1;
        end
        if (inflight) begin
            if (ob_cnt_n == 2'd0) begin
                ob0_n = sram_o2;
            end else begin
                ob1_n = sram_o2;
            end
            ob_cnt_n = ob_cnt_n + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            ob0      <= '0;
            ob1      <= '0;
            ob_cnt   <= '0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            ob_cnt   <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_fire, rd_issue})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            inflight <= rd_issue;
            ob0      <= ob0_n;
            ob1      <= ob1_n;
            ob_cnt   <= ob_cnt_n;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural model of the
// dual-port macro (port-1 write, port-2 registered read).
module tb_sram_fifo_ctrl;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst_n;
    logic              enq_valid;
    logic              enq_ready;
    logic [WIDTH-1:0]  enq_data;
    logic              deq_valid;
    logic              deq_ready;
    logic [WIDTH-1:0]  deq_data;
    logic [ADDR_W+1:0] count;
    logic [ADDR_W-1:0] sram_a1;
    logic [WIDTH-1:0]  sram_i1;
    logic              sram_csb1;
    logic              sram_web1;
    logic              sram_oeb1;
    logic [ADDR_W-1:0] sram_a2;
    logic              sram_csb2;
    logic              sram_web2;
    logic              sram_oeb2;
    logic [WIDTH-1:0]  sram_o2;
`ifdef SRAM_FIFO_FLUSH_EN
    logic              flush;
`endif

    int errors = 0;
    int checks = 0;

    sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SRAM_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_data  (deq_data),
        .count     (count),
        .sram_a1   (sram_a1),
        .sram_i1   (sram_i1),
        .sram_csb1 (sram_csb1),
        .sram_web1 (sram_web1),
        .sram_oeb1 (sram_oeb1),
        .sram_a2   (sram_a2),
        .sram_csb2 (sram_csb2),
        .sram_web2 (sram_web2),
        .sram_oeb2 (sram_oeb2),
        .sram_o2   (sram_o2)
    );

    logic [WIDTH-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
        if (!sram_csb2) sram_o2 <= mem[sram_a2];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int tx, rx, first, last, maxc, acc, got;
        sram_o2   = '0;
        rst_n     = 1'b0;
        enq_valid = 1'b1;
        enq_data  = 16'hFFFF;
        deq_ready = 1'b0;
`ifdef SRAM_FIFO_FLUSH_EN
        flush     = 1'b0;
`endif
        // In reset with enq_valid high: SRAM controls must stay inactive.
        #12;
        check("rst_csb1", sram_csb1, 1);
        check("rst_web1", sram_web1, 1);
        check("rst_oeb1", sram_oeb1, 1);
        check("rst_csb2", sram_csb2, 1);
        check("rst_oeb2", sram_oeb2, 1);
        check("rst_web2", sram_web2, 1);
        check("rst_enq_ready", enq_ready, 1);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_deq_data", deq_data, 0);
        check("rst_count", count, 0);
        enq_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_enq_ready", enq_ready, 1);
        check("idle_deq_valid", deq_valid, 0);
        check("idle_count", count, 0);
        check("idle_csb1", sram_csb1, 1);
        check("idle_csb2", sram_csb2, 1);

        // Single word: enq at E0, visible after E2, gone after E3.
        @(negedge clk);
        enq_valid = 1'b1; enq_data = 16'hA5A5; deq_ready = 1'b1;
        #1;
        check("single_csb1", sram_csb1, 0);
        @(negedge clk);
        enq_valid = 1'b0;
        #1;
        check("single_e0_count", count, 1);
        check("single_e0_dv", deq_valid, 0);
        @(negedge clk); #1;
        check("single_e1_count", count, 1);
        check("single_e1_dv", deq_valid, 0);
        @(negedge clk); #1;
        check("single_e2_dv", deq_valid, 1);
        check("single_e2_data", deq_data, 16'hA5A5);
        check("single_e2_count", count, 1);
        @(negedge clk); #1;
        check("single_e3_count", count, 0);
        check("single_e3_dv", deq_valid, 0);

        // Streaming 300 words.
        @(negedge clk);
        tx = 0; rx = 0; first = -1; last = -1; maxc = 0;
        for (int c = 0; c < 400 && rx < 300; c++) begin
            enq_valid = (tx < 300);
            enq_data  = WIDTH'(tx);
            deq_ready = 1'b1;
            #1;
            if (deq_valid) begin
                check("stream_data", deq_data, rx);
                if (first < 0) first = c;
                last = c;
                rx++;
            end
            if (int'(count) > maxc) maxc = int'(count);
            if (enq_valid && enq_ready) tx++;
            @(negedge clk);
        end
        enq_valid = 1'b0;
        check("stream_rx", rx, 300);
        check("stream_first", first, 3);
        check("stream_span", last - first, 299);
        check("stream_maxcnt", maxc, 3);

        // Fill to full with consumer stalled.
        deq_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            enq_valid = 1'b1;
            enq_data  = 16'h1000 + WIDTH'(acc);
            #1;
            if (!enq_ready) break;
            acc++;
            @(negedge clk);
        end
        enq_valid = 1'b0;
        check("full_accepted", acc, 130);
        check("full_count", count, 130);
        check("full_enq_ready", enq_ready, 0);
        @(negedge clk);
        deq_ready = 1'b1;
        #1;
        check("full_pop_dv", deq_valid, 1);
        check("full_pop_data", deq_data, 16'h1000);
        @(negedge clk);
        deq_ready = 1'b0;
        got = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (enq_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("full_ready_back", got, 1);
        @(negedge clk);
        deq_ready = 1'b1;
        rx = 1;
        for (int c = 0; c < 400 && rx < 130; c++) begin
            #1;
            if (deq_valid) begin
                check("full_drain_data", deq_data, 16'h1000 + rx);
                rx++;
            end
            @(negedge clk);
        end
        deq_ready = 1'b0;
        #1;
        check("full_drain_rx", rx, 130);
        check("full_drain_count", count, 0);

        // Random backpressure with continuous producer.
        @(negedge clk);
        tx = 0; rx = 0;
        for (int c = 0; c < 2000 && rx < 200; c++) begin
            enq_valid = (tx < 200);
            enq_data  = 16'h4000 + WIDTH'(tx);
            deq_ready = ($urandom % 2) == 1;
            #1;
            if (deq_valid && deq_ready) begin
                check("bp_data", deq_data, 16'h4000 + rx);
                rx++;
            end
            if (enq_valid && enq_ready) tx++;
            @(negedge clk);
        end
        enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("bp_rx", rx, 200);
        check("bp_count", count, 0);

        // Asynchronous reset in the middle of operation.
        @(negedge clk);
        enq_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_data = 16'h7000 + WIDTH'(i);
            @(negedge clk);
        end
        enq_valid = 1'b0;
        #1;
        check("midrst_pre_count", count, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_count", count, 0);
        check("midrst_dv", deq_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SRAM_FIFO_FLUSH_EN
        // Flush with a read in flight.
        @(negedge clk);
        enq_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            enq_data = 16'h5000 + WIDTH'(i);
            @(negedge clk);
        end
        enq_valid = 1'b0;
        repeat (4) @(negedge clk);
        deq_ready = 1'b1;
        #1;
        check("flush_pop_data", deq_data, 16'h5000);
        @(negedge clk);
        deq_ready = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_enq_ready", enq_ready, 0);
        check("flush_dv", deq_valid, 0);
        check("flush_csb2", sram_csb2, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_count", count, 0);
        check("flush_dv_after", deq_valid, 0);
        @(negedge clk);
        enq_valid = 1'b1; enq_data = 16'h1234;
        @(negedge clk);
        enq_valid = 1'b0; deq_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (deq_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("flush_resume_seen", got, 1);
        check("flush_resume_data", deq_data, 16'h1234);
        @(negedge clk);
        deq_ready = 1'b0;
        #1;
        check("flush_resume_count", count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Controller that runs one dual-port 128x16 SRAM macro as a single-clock FIFO, with a valid/ready interface on both sides. SRAM port 1 is used only for writes and port 2 only for reads. A 2-entry output buffer hides the SRAM's 1-cycle registered read latency, so dequeue can sustain 1 word/cycle. The block sits between a producer and consumer in the same clock domain; the macro is instantiated alongside it, with CE1/CE2 tied to clk.

Parameters:
WIDTH, 16, data word width (matches macro I/O width)
DEPTH, 128, SRAM entries (matches macro depth; power of 2)
ADDR_W, 7, log2(DEPTH)

Ports:
clk  input  1  clock; also drives SRAM CE1/CE2 externally
rst_n  input  1  asynchronous active-low reset
enq_valid  input  1  producer has a word
enq_ready  output  1  FIFO can accept a word this cycle
enq_data  input  WIDTH  write word
deq_valid  output  1  output-buffer head valid
deq_ready  input  1  consumer accepts the head word
deq_data  output  WIDTH  output-buffer head word
count  output  ADDR_W+2  total words held (SRAM + in-flight + output buffer); max DEPTH+2
sram_a1  output  ADDR_W  port-1 address (= wr_ptr)
sram_i1  output  WIDTH  port-1 write data (= enq_data)
sram_csb1, sram_web1, sram_oeb1  output  1 each  port-1 controls, active low
sram_a2  output  ADDR_W  port-2 address (= rd_ptr)
sram_csb2, sram_web2, sram_oeb2  output  1 each  port-2 controls, active low
sram_o2  input  WIDTH  port-2 read data (valid after the edge that issued the read)

Behaviour:
- State: wr_ptr, rd_ptr (ADDR_W, wrap modulo DEPTH); mem_cnt (0..DEPTH, words written but not yet read-issued); inflight (1 bit); ob[0:1] and ob_cnt (0..2).
- Reset values: all state 0. Outputs during and after reset: enq_ready=1, deq_valid=0, deq_data=0, count=0. All csb/web/oeb=1. While rst_n=0, SRAM controls are forced inactive.
- enq_fire = enq_valid & enq_ready. enq_ready = (mem_cnt < DEPTH). When mem_cnt==DEPTH, enq_ready is 0 even if a read issues that cycle; there is no same-cycle pass-through.
- Write: when enq_fire, drive csb1=0, web1=0, a1=wr_ptr, i1=enq_data. On the edge, wr_ptr+1 and mem_cnt+1. Port 1 otherwise idles with csb1=1. oeb1 is tied 1; web2 is tied 1.
- deq_fire = deq_valid & deq_ready. deq_valid = (ob_cnt != 0); deq_data = ob[0].
- Read issue: rd_issue = (mem_cnt != 0) & ((ob_cnt + inflight - deq_fire) < 2). When asserted, drive csb2=0, oeb2=0, a2=rd_ptr. On the edge, rd_ptr+1, mem_cnt-1, inflight<=1; otherwise inflight<=0.
- Capture: if inflight is 1, sram_o2 is appended to ob at the edge. Pop and append in the same cycle is legal: with ob_cnt=1, ob[0]<=sram_o2.
- Simultaneous enq_fire and rd_issue: mem_cnt is unchanged. A read never targets the address being written that cycle, because mem_cnt is registered and excludes the current write.
- Latency: an enq at edge E0 gives deq_valid=1 after E2 (3 cycles into an empty FIFO). Steady state is 1 word/cycle each way.
- count = mem_cnt + inflight + ob_cnt, registered-state sum.
- A reset asserted mid-operation drops all contents immediately, asynchronously.

Optional Feature:
SRAM_FIFO_FLUSH_EN
- Defined: adds input port flush (1 bit, synchronous). In a flush cycle enq_ready=0, deq_valid=0, csb1=csb2=1. At the edge, pointers, mem_cnt, inflight and ob_cnt go to 0; any in-flight read is discarded. Normal operation resumes the next cycle.
- Undefined: no flush port; the FIFO is cleared only by rst_n.

Test Plan:
- Reset then idle: rst_n low, then released -> enq_ready=1, deq_valid=0, count=0, csb1=csb2=1 with no stimulus.
- Single word: enq 16'hA5A5 at edge E0, deq_ready=1 -> deq_valid rises after E2 with deq_data=16'hA5A5; count reads 1 until the deq edge, then 0.
- Streaming: enq 0..299 back-to-back with deq_ready=1 -> dequeued in order with no bubbles after the first 3 cycles; count stays at 3 or below.
- Full: deq_ready=0, push until enq_ready drops -> exactly 130 words accepted (count=130), enq_ready=0. Pop 1 -> enq_ready returns to 1 within 2 cycles. Drain all 130 in order, including wrap of wr_ptr/rd_ptr past 127.
- Backpressure: random deq_ready (50%) with a continuous enq of an incrementing pattern -> no loss or duplication; deq_data sequence strictly incrementing.
- Flush (SRAM_FIFO_FLUSH_EN defined): fill 50 words with a read in flight, pulse flush -> next cycle count=0 and deq_valid=0. Enq 16'h1234 -> it is the next word dequeued.
